// File: rtl/and_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_pkg
//  Description : Shared constants and types for the and_gate primitive and
//                the adder blocks that consume its reduction results.
//                Contents:
//                  AND_MAX_WIDTH - widest legal operand width
//                  and_red_t     - registered {all, any} reduction pair
//  Revision    : 1.0 - initial release
// ============================================================================
package and_gate_pkg;

  localparam int AND_MAX_WIDTH = 64;

  // Reduction pair of a bitwise AND result.
  //   all - every result bit is set
  //   any - at least one result bit is set
  typedef struct packed {
    logic all;
    logic any;
  } and_red_t;

endpackage : and_gate_pkg
`default_nettype wire

// File: rtl/and_cell.sv
`default_nettype none
// ============================================================================
//  Module      : and_cell
//  Description : Single-bit 2-input AND leaf cell.
//  Ports       : a (in, 1) operand A
//                b (in, 1) operand B
//                y (out, 1) a & b, combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module and_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule : and_cell
`default_nettype wire

// File: rtl/and_gate.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate
//  Description : Bitwise 2-input AND with a zero-latency combinational
//                output plus a registered, valid-qualified copy of the
//                result and its AND/OR reductions.
//  Ports       : a         (in,  WIDTH) operand A
//                b         (in,  WIDTH) operand B
//                y         (out, WIDTH) combinational a & b
//                clk       (in,  1)     rising-edge clock, registered outputs
//                rst       (in,  1)     synchronous active-high reset
//                in_valid  (in,  1)     qualifies a/b for capture
//                y_q       (out, WIDTH) registered a & b
//                out_valid (out, 1)     y_q holds a newly captured result
//                all_q     (out, 1)     registered &(a & b)
//                any_q     (out, 1)     registered |(a & b)
//  Revision    : 1.0 - initial release
// ============================================================================
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  // a, b, y lead the list so the classic 3-port positional form still works.
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_q,
  output logic             any_q
);

  // Elaboration-time guard on the legal width range.
  if (WIDTH < 1 || WIDTH > AND_MAX_WIDTH) begin : g_width_check
    $error("and_gate: WIDTH=%0d outside 1..%0d", WIDTH, AND_MAX_WIDTH);
  end

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_out_valid;
  and_red_t         r_red;

  // One leaf cell per bit; the combinational path never sees clk/rst.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .y (w_y[i])
    );
  end

  assign y = w_y;

  // Registered stage. Reset wins over in_valid, so a capture presented in
  // the same cycle as reset is dropped. Without a valid the data registers
  // hold and only out_valid falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q       <= '0;
      r_red       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y_q     <= w_y;
        r_red.all <= &w_y;
        r_red.any <= |w_y;
      end
    end
  end

  assign y_q       = r_y_q;
  assign out_valid = r_out_valid;
  assign all_q     = r_red.all;
  assign any_q     = r_red.any;

endmodule : and_gate
`default_nettype wire

// File: tb/tb_and_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_and_gate
//  Description : Self-checking bench for and_gate. A WIDTH=1 and a WIDTH=8
//                instance share clk/rst/in_valid; the 1-bit instance sees
//                bit 0 of the 8-bit operands. Expected registered results
//                are queued when stimulus is driven and popped on output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_and_gate;

  typedef struct packed {
    logic [7:0] y;
    logic       all;
    logic       any;
  } exp_t;

  logic       clk = 1'b0;
  bit         clk_run = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a1, b1, y1, y_q1, ov1, all1, any1;
  logic [7:0] a8, b8, y8, y_q8;
  logic       ov8, all8, any8;

  exp_t exp_q[$];
  exp_t held;
  int   errors = 0;
  int   checks = 0;

  and_gate #(.WIDTH(1)) u_dut1 (
    .a(a1), .b(b1), .y(y1), .clk(clk), .rst(rst), .in_valid(in_valid),
    .y_q(y_q1), .out_valid(ov1), .all_q(all1), .any_q(any1)
  );

  and_gate #(.WIDTH(8)) u_dut8 (
    .a(a8), .b(b8), .y(y8), .clk(clk), .rst(rst), .in_valid(in_valid),
    .y_q(y_q8), .out_valid(ov8), .all_q(all8), .any_q(any8)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.y   = a & b;
    e.all = &(a & b);
    e.any = |(a & b);
    return e;
  endfunction

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic v);
    a8 = a; b8 = b; a1 = a[0]; b1 = b[0]; in_valid = v;
  endtask

  task automatic test_truth_table;
    logic [3:0] want;
    want = 4'b1000;
    rst = 1'b0; in_valid = 1'b0; a8 = '0; b8 = '0;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #1;
      checks++;
      if (y1 !== want[i]) begin
        errors++;
        $display("FAIL truth_table a=%b b=%b: got y=%b expected %b", a1, b1, y1, want[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_ops(8'hFF, 8'hFF, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (y_q8 !== 8'h00 || ov8 !== 1'b0 || all8 !== 1'b0 || any8 !== 1'b0) begin
        errors++;
        $display("FAIL reset8 cyc%0d: got y_q=%h ov=%b all=%b any=%b expected 00 0 0 0",
                 c, y_q8, ov8, all8, any8);
      end
      checks++;
      if (y_q1 !== 1'b0 || ov1 !== 1'b0 || all1 !== 1'b0 || any1 !== 1'b0) begin
        errors++;
        $display("FAIL reset1 cyc%0d: got y_q=%b ov=%b all=%b any=%b expected 0 0 0 0",
                 c, y_q1, ov1, all1, any1);
      end
      checks++;
      if (y8 !== 8'hFF || y1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_comb cyc%0d: got y8=%h y1=%b expected ff 1", c, y8, y1);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    held = '0;
    exp_q.delete();
  endtask

  task automatic test_capture_hold;
    exp_t e;
    @(negedge clk);
    set_ops(8'hF0, 8'h3C, 1'b1);
    exp_q.push_back(model(8'hF0, 8'h3C));
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL capture_valid: got out_valid=%b expected 1", ov8);
    end else begin
      e = exp_q.pop_front();
      held = e;
      checks++;
      if (y_q8 !== e.y || y_q8 !== 8'h30 || any8 !== 1'b1 || all8 !== 1'b0) begin
        errors++;
        $display("FAIL capture_data: got y_q=%h any=%b all=%b expected 30 1 0", y_q8, any8, all8);
      end
    end
    @(negedge clk);
    set_ops(8'hFF, 8'hFF, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (y_q8 !== 8'h30 || ov8 !== 1'b0 || y8 !== 8'hFF) begin
      errors++;
      $display("FAIL hold: got y_q=%h ov=%b y=%h expected 30 0 ff", y_q8, ov8, y8);
    end
  endtask

  task automatic test_reductions;
    exp_t e;
    logic [7:0] ops [2];
    ops[0] = 8'hFF;
    ops[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_ops(ops[k], 8'hFF, 1'b1);
      exp_q.push_back(model(ops[k], 8'hFF));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      held = e;
      checks++;
      if (all8 !== e.all || any8 !== e.any || y_q8 !== e.y || ov8 !== 1'b1) begin
        errors++;
        $display("FAIL reductions8 a=%h: got all=%b any=%b y_q=%h expected %b %b %h",
                 ops[k], all8, any8, y_q8, e.all, e.any, e.y);
      end
      checks++;
      if (all1 !== e.y[0] || any1 !== e.y[0] || y_q1 !== e.y[0]) begin
        errors++;
        $display("FAIL reductions1 a=%h: got all=%b any=%b y_q=%b expected %b",
                 ops[k], all1, any1, y_q1, e.y[0]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    @(negedge clk);
    set_ops(8'hAA, 8'hFF, 1'b1);
    exp_q.push_back(model(8'hAA, 8'hFF));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (y_q8 !== e.y || ov8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got y_q=%h ov=%b expected %h 1", y_q8, ov8, e.y);
    end
    @(negedge clk);
    rst = 1'b1;
    set_ops(8'h55, 8'hFF, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b0 || y_q8 !== 8'h00 || all8 !== 1'b0 || any8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b y_q=%h all=%b any=%b expected 0 00 0 0",
               ov8, y_q8, all8, any8);
    end
    held = '0;
    @(negedge clk);
    rst = 1'b0;
    set_ops(8'h0F, 8'hFF, 1'b1);
    exp_q.push_back(model(8'h0F, 8'hFF));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    held = e;
    checks++;
    if (ov8 !== 1'b1 || y_q8 !== e.y || any8 !== 1'b1 || all8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_recover: got ov=%b y_q=%h any=%b all=%b expected 1 %h 1 0",
               ov8, y_q8, any8, all8, e.y);
    end
  endtask

  task automatic test_random;
    logic exp_ov;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      set_ops(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      #1;
      checks++;
      if (y8 !== (a8 & b8) || y1 !== (a1 & b1)) begin
        errors++;
        $display("FAIL rand_comb n=%0d: got y8=%h y1=%b expected %h %b",
                 n, y8, y1, a8 & b8, a1 & b1);
      end
      exp_ov = in_valid;
      if (in_valid) exp_q.push_back(model(a8, b8));
      @(posedge clk); #1;
      checks++;
      if (ov8 !== exp_ov || ov1 !== exp_ov) begin
        errors++;
        $display("FAIL rand_valid n=%0d: got ov8=%b ov1=%b expected %b", n, ov8, ov1, exp_ov);
      end
      if (exp_ov && exp_q.size() != 0) held = exp_q.pop_front();
      checks++;
      if (y_q8 !== held.y || all8 !== held.all || any8 !== held.any) begin
        errors++;
        $display("FAIL rand_reg8 n=%0d: got y_q=%h all=%b any=%b expected %h %b %b",
                 n, y_q8, all8, any8, held.y, held.all, held.any);
      end
      checks++;
      if (y_q1 !== held.y[0] || all1 !== held.y[0] || any1 !== held.y[0]) begin
        errors++;
        $display("FAIL rand_reg1 n=%0d: got y_q=%b all=%b any=%b expected %b",
                 n, y_q1, all1, any1, held.y[0]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d queued results expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_truth_table();
    clk_run = 1'b1;
    test_reset();
    test_capture_hold();
    test_reductions();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_and_gate
`default_nettype wire
